jk_excitation_ctrl: RTL and testbench

Command-driven controller that works the JK protocol in the opposite direction from a JK flip-flop. The flip-flop maps J/K to a next state. This block takes a desired next state and produces the J/K excitation that reaches it. It applies that excitation to an internal WIDTH-bit JK register bank and exports J, K and Q, so a bench or a downstream JK bank can follow the same excitation. It sits between a command source (sequencer or testbench) and JK-based storage/counter logic.

---
 rtl/jk_excitation_ctrl_if.sv | 26 ++
 rtl/jk_excitation_ctrl.sv | 108 ++++++++++
 tb/tb_jk_excitation_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/jk_excitation_ctrl_if.sv
// Command and excitation bundle for jk_excitation_ctrl; master is the command source, slave is the controller.
interface jk_excitation_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [7:0]       cmd_count;
  logic [WIDTH-1:0] J;
  logic [WIDTH-1:0] K;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] NQ;
  logic             busy;
  logic             done;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_count,
    input  cmd_ready, J, K, Q, NQ, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_count,
    output cmd_ready, J, K, Q, NQ, busy, done
  );
endinterface

// File: rtl/jk_excitation_ctrl.sv
// Turns a desired next state into J/K excitation for a WIDTH-bit JK bank; JK_TOGGLE_PREF_EN picks toggle-form don't-cares.
// Latency: done n+1 cycles after accept (n = count or 1); backpressure: cmd_ready only in IDLE, commands are never queued.
module jk_excitation_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic C,
  input  logic CLEAR,
  jk_excitation_ctrl_if.slave bus
);
  localparam logic [2:0] OP_HOLD  = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_UP    = 3'b010;
  localparam logic [2:0] OP_DOWN  = 3'b011;
  localparam logic [2:0] OP_TOGL  = 3'b100;
  localparam logic [2:0] OP_CLRM  = 3'b101;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  typedef struct packed {
    logic [2:0]       op;
    logic [WIDTH-1:0] data;
  } cmd_t;

  state_t           state_q, state_d;
  cmd_t             cmd_q, cmd_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] tgt;
  logic [WIDTH-1:0] j_v, k_v;
  logic             in_is_count;

  // Desired next state of the bank for the latched command.
  always_comb begin
    tgt = q_q;
    case (cmd_q.op)
      OP_LOAD: tgt = cmd_q.data;
      OP_UP:   tgt = q_q + WIDTH'(1);
      OP_DOWN: tgt = q_q - WIDTH'(1);
      OP_TOGL: tgt = q_q ^ cmd_q.data;
      OP_CLRM: tgt = q_q & ~cmd_q.data;
      default: tgt = q_q;
    endcase
  end

  always_comb begin
    j_v = '0;
    k_v = '0;
    if (state_q == ST_RUN) begin
`ifdef JK_TOGGLE_PREF_EN
      j_v = q_q ^ tgt;
      k_v = q_q ^ tgt;
`else
      j_v = ~q_q & tgt;
      k_v = q_q & ~tgt;
`endif
    end
  end

  assign in_is_count = (bus.cmd_op == OP_UP) || (bus.cmd_op == OP_DOWN);

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    cnt_d   = cnt_q;
    // JK characteristic; J=K=0 outside RUN, so Q holds there.
    q_d     = (j_v & ~q_q) | (~k_v & q_q);
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          cmd_d.op   = bus.cmd_op;
          cmd_d.data = bus.cmd_data;
          cnt_d      = in_is_count ? bus.cmd_count : 8'd1;
          state_d    = (in_is_count && (bus.cmd_count == 8'd0)) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q <= 8'd1) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge C) begin
    if (CLEAR) begin
      state_q <= ST_IDLE;
      cmd_q   <= '{op: OP_HOLD, data: '0};
      cnt_q   <= 8'd0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
    end
  end

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.J         = j_v;
  assign bus.K         = k_v;
  assign bus.Q         = q_q;
  assign bus.NQ        = ~q_q;
endmodule

// File: tb/tb_jk_excitation_ctrl.sv
// Directed and randomized checks of jk_excitation_ctrl against an arithmetic reference model.
module tb_jk_excitation_ctrl;
  localparam int W    = 4;
  localparam int MODV = 1 << W;

  logic C = 1'b0;
  logic CLEAR;
  int   total = 0;
  int   bad   = 0;
  int   exp_q = 0;

  jk_excitation_ctrl_if #(.WIDTH(W)) bus ();

  jk_excitation_ctrl #(.WIDTH(W)) dut (
    .C     (C),
    .CLEAR (CLEAR),
    .bus   (bus)
  );

  always #5 C = ~C;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge C);
    #1;
  endtask

  function automatic int model_target(input int op, input int data, input int q);
    case (op)
      1:       return data % MODV;
      2:       return (q + 1) % MODV;
      3:       return (q + MODV - 1) % MODV;
      4:       return (q ^ data) % MODV;
      5:       return q & ~data & (MODV - 1);
      default: return q;
    endcase
  endfunction

  // Per-bit excitation table lookup for a Q -> T transition.
  task automatic model_exc(input int q, input int t, output int j, output int k);
    j = 0;
    k = 0;
    for (int b = 0; b < W; b++) begin
      int qb;
      int tb;
      qb = (q >> b) & 1;
      tb = (t >> b) & 1;
`ifdef JK_TOGGLE_PREF_EN
      if (qb != tb) begin
        j += (1 << b);
        k += (1 << b);
      end
`else
      if (qb == 0 && tb == 1) j += (1 << b);
      if (qb == 1 && tb == 0) k += (1 << b);
`endif
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, bus.cmd_ready, 1);
    check({tag, "_busy"},  bus.busy, 0);
    check({tag, "_done"},  bus.done, 0);
    check({tag, "_j"},     bus.J, 0);
    check({tag, "_k"},     bus.K, 0);
    check({tag, "_q"},     bus.Q, exp_q);
    check({tag, "_nq"},    bus.NQ, (~exp_q) & (MODV - 1));
  endtask

  task automatic do_cmd(input int op, input int data, input int count);
    int n, t, ej, ek;
    check("accept_ready", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'(op);
    bus.cmd_data  = W'(data);
    bus.cmd_count = 8'(count);
    step();
    bus.cmd_valid = 1'b0;
    n = (op == 2 || op == 3) ? count : 1;
    for (int i = 0; i < n; i++) begin
      t = model_target(op, data, exp_q);
      model_exc(exp_q, t, ej, ek);
      check("run_busy",  bus.busy, 1);
      check("run_ready", bus.cmd_ready, 0);
      check("run_done",  bus.done, 0);
      check("run_j",     bus.J, ej);
      check("run_k",     bus.K, ek);
      check("run_q",     bus.Q, exp_q);
      step();
      exp_q = t;
    end
    check("done_pulse", bus.done, 1);
    check("done_busy",  bus.busy, 1);
    check("done_ready", bus.cmd_ready, 0);
    check("done_j",     bus.J, 0);
    check("done_k",     bus.K, 0);
    check("done_q",     bus.Q, exp_q);
    check("done_nq",    bus.NQ, (~exp_q) & (MODV - 1));
    step();
    check_idle("post");
  endtask

  initial begin
    int ej, ek;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_data  = '0;
    bus.cmd_count = 8'd0;
    CLEAR = 1'b1;
    step();
    step();
    CLEAR = 1'b0;
    exp_q = 0;
    check_idle("reset");

    // LOAD sequence, including a mixed set/reset excitation
    do_cmd(1, 4'b1010, 0);
    do_cmd(1, 4'b0110, 0);

    // COUNT_UP across the all-ones wrap
    do_cmd(1, 4'b1110, 0);
    do_cmd(2, 0, 3);

    // COUNT_DOWN wrap and zero-count COUNT_UP
    do_cmd(1, 0, 0);
    do_cmd(3, 0, 1);
    do_cmd(2, 0, 0);

    // TOGGLE, CLRMASK, reserved op
    do_cmd(1, 4'b0101, 0);
    do_cmd(4, 4'b0011, 0);
    do_cmd(5, 4'b0100, 0);
    do_cmd(7, 4'b1111, 0);
    do_cmd(6, 4'b1001, 5);
    do_cmd(0, 4'b1111, 9);

    // CLEAR mid-count abandons the command without a done pulse
    do_cmd(1, 0, 0);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'd2;
    bus.cmd_count = 8'd10;
    step();
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("abort_run_q", bus.Q, i);
      step();
    end
    check("abort_4th_busy", bus.busy, 1);
    CLEAR = 1'b1;
    step();
    CLEAR = 1'b0;
    exp_q = 0;
    check_idle("abort");
    step();
    check_idle("abort_late");

    // CLEAR together with cmd_valid: command is not taken
    do_cmd(1, 4'b0011, 0);
    CLEAR = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'd1;
    bus.cmd_data  = 4'b1001;
    step();
    CLEAR = 1'b0;
    bus.cmd_valid = 1'b0;
    exp_q = 0;
    check_idle("clr_vs_cmd");

    // A command held while busy waits for cmd_ready
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'd2;
    bus.cmd_count = 8'd2;
    step();
    bus.cmd_op    = 3'd1;
    bus.cmd_data  = 4'b1001;
    check("hold_run1_q", bus.Q, 0);
    check("hold_run1_rdy", bus.cmd_ready, 0);
    step();
    check("hold_run2_q", bus.Q, 1);
    check("hold_run2_rdy", bus.cmd_ready, 0);
    step();
    check("hold_done_q", bus.Q, 2);
    check("hold_done", bus.done, 1);
    step();
    exp_q = 2;
    check_idle("hold_idle");
    step();
    bus.cmd_valid = 1'b0;
    model_exc(2, 9, ej, ek);
    check("hold_acc_busy", bus.busy, 1);
    check("hold_acc_j", bus.J, ej);
    check("hold_acc_k", bus.K, ek);
    step();
    exp_q = 9;
    check("hold_acc_q", bus.Q, exp_q);
    check("hold_acc_done", bus.done, 1);
    step();
    check_idle("hold_end");

    // Randomized commands
    for (int r = 0; r < 40; r++) begin
      int op, data, cnt;
      op   = $urandom_range(0, 7);
      data = $urandom_range(0, MODV - 1);
      cnt  = $urandom_range(0, 12);
      do_cmd(op, data, cnt);
      if ($urandom_range(0, 3) == 0) begin
        step();
        check_idle("rand_gap");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
